// File: rtl/conv_img_feeder.sv
// conv_img_feeder
// Buffers one IMG_H x IMG_W 8-bit image arriving in raster order, then pushes
// it to an NPU control bus as 3-row windows. Each window row gets a clear
// write, then one write per image column carrying that column's three
// vertically stacked pixels. After the third column, every column write is
// followed by a trigger write and WAIT_CYC idle cycles.
//
// Ports
//   clk        rising-edge clock
//   rst_ni     asynchronous active-low reset
//   s_valid    pixel stream valid
//   s_data     8-bit pixel, raster order
//   s_ready    feeder accepts a pixel (LOAD only)
//   m_ena      NPU bus enable (write cycles only)
//   m_wea      NPU bus write enable (equals m_ena; reads are never issued)
//   m_addra    NPU bus address {1'b0, sel[2:0], 12'h000}
//   m_dina     NPU bus write data
//   busy       high from the first CLR write until DONE
//   done       one-cycle pulse once the whole image has been issued
//   win_cnt    trigger writes issued for the current image (saturating)
//   dbg_state  current FSM state
//
// Stream handshake: a pixel moves on a rising edge where s_valid and s_ready
// are both high. s_ready never depends on s_valid. s_valid may be high at any
// time; while s_ready is low the pixel is not consumed and has no effect.
module conv_img_feeder #(
  parameter int IMG_H    = 16,
  parameter int IMG_W    = 15,
  parameter int K        = 3,
  parameter int WAIT_CYC = 3
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        m_ena,
  output logic        m_wea,
  output logic [15:0] m_addra,
  output logic [31:0] m_dina,
  output logic        busy,
  output logic        done,
  output logic [7:0]  win_cnt,
  output logic [2:0]  dbg_state
);

  localparam int NPIX  = IMG_H * IMG_W;
  localparam int IDX_W = $clog2(NPIX);
  localparam int WR_W  = $clog2(IMG_H);
  localparam int C_W   = $clog2(IMG_W);
  localparam int WT_W  = $clog2(WAIT_CYC + 1);

  localparam logic [15:0] ADDR_CTRL = {1'b0, 3'b100, 12'h000};
  localparam logic [15:0] ADDR_COL  = {1'b0, 3'b001, 12'h000};
  localparam logic [31:0] CMD_CLR   = 32'h0000_0008;
  localparam logic [31:0] CMD_TRIG  = 32'h0000_0001;

  typedef enum logic [2:0] {
    LOAD = 3'd0,
    CLR  = 3'd1,
    COL  = 3'd2,
    TRIG = 3'd3,
    GAP  = 3'd4,
    WAIT = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WR_W-1:0]   wr_q, wr_d;
  logic [C_W-1:0]    c_q, c_d;
  logic [WT_W-1:0]   wt_q, wt_d;
  logic [7:0]        win_cnt_q, win_cnt_d;
  // Remembers whether the current GAP follows a COL write (else a CLR write).
  logic              gap_col_q, gap_col_d;
  // Holds s_ready low until the first clock edge after reset release.
  logic              armed_q;
  logic              accept;

  logic [7:0]        pix_q [NPIX];
  logic [IDX_W-1:0]  rd0, rd1, rd2;

  // Raster indices of the three window-row pixels in column c.
  assign rd0 = IDX_W'(wr_q) * IDX_W'(IMG_W) + IDX_W'(c_q);
  assign rd1 = rd0 + IDX_W'(IMG_W);
  assign rd2 = rd1 + IDX_W'(IMG_W);

  // Pixel buffer: no reset, contents are always rewritten before use.
  always_ff @(posedge clk) begin
    if (accept) pix_q[idx_q] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= LOAD;
      idx_q     <= '0;
      wr_q      <= '0;
      c_q       <= '0;
      wt_q      <= '0;
      win_cnt_q <= '0;
      gap_col_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      c_q       <= c_d;
      wt_q      <= wt_d;
      win_cnt_q <= win_cnt_d;
      gap_col_q <= gap_col_d;
      armed_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    c_d       = c_q;
    wt_d      = wt_q;
    win_cnt_d = win_cnt_q;
    gap_col_d = gap_col_q;
    accept    = 1'b0;
    s_ready   = 1'b0;
    m_ena     = 1'b0;
    m_wea     = 1'b0;
    m_addra   = '0;
    m_dina    = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      LOAD: begin
        s_ready = armed_q;
        if (s_valid && armed_q) begin
          accept = 1'b1;
          if (idx_q == IDX_W'(NPIX - 1)) begin
            idx_d   = '0;
            wr_d    = '0;
            state_d = CLR;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      CLR: begin
        busy      = 1'b1;
        m_ena     = 1'b1;
        m_wea     = 1'b1;
        m_addra   = ADDR_CTRL;
        m_dina    = CMD_CLR;
        c_d       = '0;
        gap_col_d = 1'b0;
        state_d   = GAP;
      end
      COL: begin
        busy      = 1'b1;
        m_ena     = 1'b1;
        m_wea     = 1'b1;
        m_addra   = ADDR_COL;
        m_dina    = {8'h00, pix_q[rd2], pix_q[rd1], pix_q[rd0]};
        gap_col_d = 1'b1;
        state_d   = GAP;
      end
      GAP: begin
        busy = 1'b1;
        if (!gap_col_q) begin
          state_d = COL;
        end else if (c_q >= C_W'(K - 1)) begin
          // A full K-wide window is now loaded: fire it.
          state_d = TRIG;
        end else begin
          c_d     = c_q + 1'b1;
          state_d = COL;
        end
      end
      TRIG: begin
        busy    = 1'b1;
        m_ena   = 1'b1;
        m_wea   = 1'b1;
        m_addra = ADDR_CTRL;
        m_dina  = CMD_TRIG;
        if (win_cnt_q != 8'hFF) win_cnt_d = win_cnt_q + 8'd1;
        wt_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (wt_q == WT_W'(WAIT_CYC - 1)) begin
          if (c_q != C_W'(IMG_W - 1)) begin
            c_d     = c_q + 1'b1;
            state_d = COL;
          end else if (wr_q != WR_W'(IMG_H - K)) begin
            wr_d    = wr_q + 1'b1;
            state_d = CLR;
          end else begin
            state_d = DONE;
          end
        end else begin
          wt_d = wt_q + 1'b1;
        end
      end
      DONE: begin
        done      = 1'b1;
        win_cnt_d = '0;
        state_d   = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  assign win_cnt   = win_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_img_feeder.sv
// Testbench for conv_img_feeder. Two instances share the clock: dut0 uses
// WAIT_CYC=3, dut1 uses WAIT_CYC=5. For every loaded image the bench builds
// the complete expected per-cycle output schedule from the window-row rules
// and compares it on every falling edge; a second monitor checks the bus
// spacing rules and per-image totals independently.
module tb_conv_img_feeder;
  localparam int H    = 16;
  localparam int W    = 15;
  localparam int NPIX = H * W;
  localparam int WC0  = 3;
  localparam int WC1  = 5;

  typedef struct packed {
    logic        ena;
    logic [15:0] addr;
    logic [31:0] dina;
    logic        done;
    logic        busy;
    logic        rdy;
    logic [7:0]  wcnt;
  } exp_t;

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n0, rst_n1, sv0, sv1;
  logic [7:0]  sd0, sd1;
  logic        s_ready0, m_ena0, m_wea0, busy0, done0;
  logic        s_ready1, m_ena1, m_wea1, busy1, done1;
  logic [15:0] m_addra0, m_addra1;
  logic [31:0] m_dina0, m_dina1;
  logic [7:0]  win_cnt0, win_cnt1;
  logic [2:0]  dbg0, dbg1;

  conv_img_feeder #(.IMG_H(H), .IMG_W(W), .K(3), .WAIT_CYC(WC0)) dut0 (
    .clk(clk), .rst_ni(rst_n0), .s_valid(sv0), .s_data(sd0), .s_ready(s_ready0),
    .m_ena(m_ena0), .m_wea(m_wea0), .m_addra(m_addra0), .m_dina(m_dina0),
    .busy(busy0), .done(done0), .win_cnt(win_cnt0), .dbg_state(dbg0)
  );

  conv_img_feeder #(.IMG_H(H), .IMG_W(W), .K(3), .WAIT_CYC(WC1)) dut1 (
    .clk(clk), .rst_ni(rst_n1), .s_valid(sv1), .s_data(sd1), .s_ready(s_ready1),
    .m_ena(m_ena1), .m_wea(m_wea1), .m_addra(m_addra1), .m_dina(m_dina1),
    .busy(busy1), .done(done1), .win_cnt(win_cnt1), .dbg_state(dbg1)
  );

  // ---------------- scoreboard state ----------------
  exp_t       exp_q0[$];
  exp_t       exp_q1[$];
  logic [7:0] img [2][NPIX];
  bit         armed [2];
  int         n_pass  = 0;
  int         n_total = 0;

  bit prev_ena [2];
  bit started [2];
  int since_trig [2];
  int trigs [2];
  int clrs [2];
  int cyc [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic get_out(input int w, output exp_t a, output logic wea);
    if (w == 0) begin
      a.ena = m_ena0; a.addr = m_addra0; a.dina = m_dina0; a.done = done0;
      a.busy = busy0; a.rdy = s_ready0; a.wcnt = win_cnt0; wea = m_wea0;
    end else begin
      a.ena = m_ena1; a.addr = m_addra1; a.dina = m_dina1; a.done = done1;
      a.busy = busy1; a.rdy = s_ready1; a.wcnt = win_cnt1; wea = m_wea1;
    end
  endtask

  function automatic void push_e(input int w, input exp_t e);
    if (w == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endfunction

  function automatic int qsize(input int w);
    return (w == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic exp_t peek(input int w, input int i);
    return (w == 0) ? exp_q0[i] : exp_q1[i];
  endfunction

  function automatic exp_t wr_ent(input logic [15:0] a, input logic [31:0] d, input int tc);
    exp_t e;
    e = '0; e.ena = 1'b1; e.addr = a; e.dina = d; e.busy = 1'b1; e.wcnt = 8'(tc);
    return e;
  endfunction

  function automatic exp_t idle_ent(input int tc);
    exp_t e;
    e = '0; e.busy = 1'b1; e.wcnt = 8'(tc);
    return e;
  endfunction

  // Expected outputs for every cycle from the last LOAD cycle to DONE.
  task automatic build_sched(input int w, input int wc);
    exp_t e;
    int tc;
    logic [31:0] d;
    e = '0; e.rdy = 1'b1;
    push_e(w, e);
    tc = 0;
    for (int wr = 0; wr <= H - 3; wr++) begin
      push_e(w, wr_ent(16'h4000, 32'h8, tc));
      push_e(w, idle_ent(tc));
      for (int c = 0; c < W; c++) begin
        d = {8'h00, img[w][(wr + 2) * W + c], img[w][(wr + 1) * W + c], img[w][wr * W + c]};
        push_e(w, wr_ent(16'h1000, d, tc));
        push_e(w, idle_ent(tc));
        if (c >= 2) begin
          push_e(w, wr_ent(16'h4000, 32'h1, tc));
          if (tc < 255) tc++;
          for (int k = 0; k < wc; k++) push_e(w, idle_ent(tc));
        end
      end
    end
    e = '0; e.done = 1'b1; e.wcnt = 8'(tc);
    push_e(w, e);
  endtask

  // Hand-computed anchors for a ramp image (pixel = raster index mod 256).
  task automatic pin_model(input int w, input int wc);
    int sz;
    exp_t e;
    sz = qsize(w);
    check("model_len", sz, 2 + 14 * (32 + 13 * (1 + wc)));
    e = peek(w, 1);  check("model_clr",  {e.ena, e.addr, e.dina}, {1'b1, 16'h4000, 32'h0000_0008});
    e = peek(w, 3);  check("model_col0", {e.ena, e.addr, e.dina}, {1'b1, 16'h1000, 32'h001E_0F00});
    e = peek(w, 5);  check("model_col1", e.dina, 32'h001F_1001);
    e = peek(w, 7);  check("model_col2", e.dina, 32'h0020_1102);
    e = peek(w, 9);  check("model_trig0", {e.ena, e.addr, e.dina}, {1'b1, 16'h4000, 32'h0000_0001});
    e = peek(w, sz - 4 - wc); check("model_last_col", {e.addr, e.dina}, {16'h1000, 32'h00EF_E0D1});
    e = peek(w, sz - 2 - wc); check("model_last_trig", e.dina, 32'h0000_0001);
    e = peek(w, sz - 1); check("model_done", {e.done, e.wcnt}, {1'b1, 8'd182});
  endtask

  // ---------------- compare + rule monitor ----------------
  task automatic cmp_cycle(input int w);
    exp_t e, a;
    logic wea;
    get_out(w, a, wea);
    if (qsize(w) > 0) begin
      if (w == 0) e = exp_q0.pop_front();
      else e = exp_q1.pop_front();
    end else begin
      e = '0; e.rdy = armed[w];
    end
    check($sformatf("cycle_dut%0d", w), {a, wea}, {e, e.ena});
  endtask

  function automatic void mon_clear(input int w);
    prev_ena[w] = 1'b0; started[w] = 1'b0; since_trig[w] = -1;
    trigs[w] = 0; clrs[w] = 0; cyc[w] = 0;
  endfunction

  task automatic mon_cycle(input int w, input int wc);
    exp_t a;
    logic wea;
    get_out(w, a, wea);
    if (prev_ena[w]) check($sformatf("idle_after_write_dut%0d", w), a.ena, 1'b0);
    prev_ena[w] = a.ena;
    if (since_trig[w] >= 0) since_trig[w]++;
    if (a.ena && since_trig[w] > 0) begin
      check($sformatf("trig_spacing_dut%0d", w), since_trig[w], wc + 1);
      since_trig[w] = -1;
    end
    if (started[w]) cyc[w]++;
    if (a.ena && a.addr == 16'h4000 && a.dina == 32'h8) begin
      if (!started[w]) begin started[w] = 1'b1; cyc[w] = 0; end
      clrs[w]++;
    end
    if (a.ena && a.addr == 16'h4000 && a.dina == 32'h1) begin
      trigs[w]++;
      since_trig[w] = 0;
    end
    if (a.done) begin
      check($sformatf("done_latency_dut%0d", w), cyc[w], 14 * (32 + 13 * (1 + wc)));
      check($sformatf("trig_total_dut%0d", w), trigs[w], 182);
      check($sformatf("clr_total_dut%0d", w), clrs[w], 14);
      check($sformatf("win_cnt_at_done_dut%0d", w), a.wcnt, 8'd182);
      mon_clear(w);
    end
  endtask

  always @(negedge clk) begin
    cmp_cycle(0);
    cmp_cycle(1);
    mon_cycle(0, WC0);
    mon_cycle(1, WC1);
  end

  // ---------------- drivers ----------------
  task automatic set_in(input int w, input logic v, input logic [7:0] d);
    if (w == 0) begin sv0 = v; sd0 = d; end
    else begin sv1 = v; sd1 = d; end
  endtask

  function automatic logic rdy(input int w);
    return (w == 0) ? s_ready0 : s_ready1;
  endfunction

  // Called just after a rising edge; a pixel counts when valid and ready
  // are both high for the coming edge.
  task automatic feed_image(input int w, input int wc, input bit ramp, input bit rand_valid);
    int idx = 0;
    int budget = 0;
    logic v;
    logic [7:0] d;
    while (idx < NPIX && budget < 5000) begin
      v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      d = ramp ? 8'(idx) : 8'($urandom_range(0, 255));
      set_in(w, v, d);
      if (v && rdy(w)) begin
        img[w][idx] = d;
        idx++;
        if (idx == NPIX) begin
          build_sched(w, wc);
          if (ramp) pin_model(w, wc);
        end
      end
      @(posedge clk); #1;
      budget++;
    end
    if (idx < NPIX) check($sformatf("load_timeout_dut%0d", w), idx, NPIX);
  endtask

  // Keep s_valid high with junk data while the image is issued.
  task automatic hold_issue(input int w);
    int budget = 0;
    while (qsize(w) > 1 && budget < 3000) begin
      set_in(w, 1'b1, 8'($urandom_range(0, 255)));
      @(posedge clk); #1;
      budget++;
    end
    if (qsize(w) > 1) check($sformatf("issue_timeout_dut%0d", w), qsize(w), 1);
  endtask

  task automatic check_zero_outs(input int w, input string name);
    exp_t a;
    logic wea;
    get_out(w, a, wea);
    check(name, {a, wea}, '0);
  endtask

  task automatic seq0();
    feed_image(0, WC0, 1'b1, 1'b1);
    hold_issue(0);
    feed_image(0, WC0, 1'b0, 1'b1);
    hold_issue(0);
    feed_image(0, WC0, 1'b1, 1'b1);
    // Now in the first CLR cycle; move to the middle of window row 5.
    repeat (5 * 84 + 40) begin
      set_in(0, 1'b1, 8'($urandom_range(0, 255)));
      @(posedge clk); #1;
    end
    check("busy_before_reset", busy0, 1'b1);
    #3;
    rst_n0 = 1'b0;
    exp_q0.delete();
    armed[0] = 1'b0;
    mon_clear(0);
    set_in(0, 1'b0, 8'h00);
    #1;
    check_zero_outs(0, "mid_image_reset_outs");
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst_n0 = 1'b1;
    check("ready_low_after_release", s_ready0, 1'b0);
    @(posedge clk); #1;
    armed[0] = 1'b1;
    check("ready_after_first_clock", s_ready0, 1'b1);
    feed_image(0, WC0, 1'b1, 1'b0);
    hold_issue(0);
    set_in(0, 1'b0, 8'h00);
  endtask

  task automatic seq1();
    feed_image(1, WC1, 1'b1, 1'b0);
    hold_issue(1);
    set_in(1, 1'b0, 8'h00);
  endtask

  // ---------------- main ----------------
  initial begin
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    sv0 = 1'b0; sv1 = 1'b0; sd0 = 8'h00; sd1 = 8'h00;
    armed[0] = 1'b0; armed[1] = 1'b0;
    mon_clear(0);
    mon_clear(1);
    #2;
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    #1;
    check_zero_outs(0, "reset_outs_dut0");
    check_zero_outs(1, "reset_outs_dut1");
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    check("ready_low_before_first_clock", s_ready0, 1'b0);
    @(posedge clk); #1;
    armed[0] = 1'b1; armed[1] = 1'b1;
    check("ready_high_after_first_clock", s_ready1, 1'b1);
    fork
      seq0();
      seq1();
    join
    repeat (4) @(posedge clk);
    check("queue_drained_dut0", exp_q0.size(), 0);
    check("queue_drained_dut1", exp_q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/conv_img_feeder.md
CONV_IMG_FEEDER -- requirements
Module: conv_img_feeder

Interface
REQ-001 Parameter IMG_H, default 16, image rows.
REQ-002 Parameter IMG_W, default 15, image columns.
REQ-003 Parameter K, default 3, kernel height/width; the design SHALL support only K=3.
REQ-004 Parameter WAIT_CYC, default 3, idle cycles after each trigger write.
REQ-005 Port clk, input, 1, sole clock; all logic SHALL be rising-edge.
REQ-006 Port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 Port s_valid, input, 1, pixel stream valid.
REQ-008 Port s_data, input, 8, unsigned pixel in raster order (row-major).
REQ-009 Port s_ready, output, 1, feeder accepts a pixel.
REQ-010 Port m_ena, output, 1, NPU bus enable.
REQ-011 Port m_wea, output, 1, NPU bus write enable.
REQ-012 Port m_addra, output, 16, NPU bus address, {1'b0, sel[2:0], 12'h000}.
REQ-013 Port m_dina, output, 32, NPU bus write data.
REQ-014 Port busy, output, 1, high from first CLR write until done.
REQ-015 Port done, output, 1, one-cycle pulse when the image is fully issued.
REQ-016 Port win_cnt, output, 8, count of trigger writes issued for the current image.

Function
REQ-017 The FSM SHALL have states LOAD, CLR, COL, TRIG, GAP, WAIT and DONE.
REQ-018 In LOAD, s_ready=1 and each s_valid&s_ready handshake SHALL store s_data at raster index r*IMG_W+c.
REQ-019 In all states other than LOAD, s_ready SHALL be 0.
REQ-020 On acceptance of pixel IMG_H*IMG_W-1, the FSM SHALL go to CLR with window row wr=0.
- The first bus write appears in the next cycle.
REQ-021 Every bus transaction SHALL be a single write cycle with m_ena=m_wea=1.
- It SHALL be followed by at least one cycle with m_ena=m_wea=0 (GAP or WAIT).
- Reads SHALL never be issued.
REQ-022 Outside write cycles, m_ena, m_wea, m_addra and m_dina SHALL all be 0.
REQ-023 CLR write (sel=3'b100, m_dina=32'h0000_0008) SHALL clear the NPU image window at the start of each window row; then GAP, then COL with column c=0.
REQ-024 COL write (sel=3'b001) SHALL carry pix[wr][c] on [7:0], pix[wr+1][c] on [15:8], pix[wr+2][c] on [23:16], and 0 on [31:24].
REQ-025 After a COL write, the FSM SHALL pass through GAP (1 cycle).
- If c>=2, it SHALL then issue TRIG.
- Otherwise it SHALL issue the next COL.
REQ-026 TRIG write (sel=3'b100, m_dina=32'h0000_0001) SHALL increment win_cnt and be followed by exactly WAIT_CYC idle cycles in WAIT.
REQ-027 After WAIT, if c<IMG_W-1, the FSM SHALL increment c and issue COL.
- Otherwise, if wr<IMG_H-3, it SHALL increment wr and issue CLR.
- Otherwise it SHALL go to DONE.
REQ-028 DONE SHALL assert done=1 for one cycle, clear busy, zero win_cnt on the next cycle, and return to LOAD.
REQ-029 Per window row, the feeder SHALL issue 1 CLR, IMG_W COL and IMG_W-2 TRIG writes.
- With defaults, each window row SHALL take 2+30+13*(1+WAIT_CYC)=84 cycles.
- A full image SHALL take 14*84=1176 cycles, with 182 triggers.
REQ-030 win_cnt SHALL saturate at 255.
REQ-031 A s_valid held high in non-LOAD states SHALL have no effect; the pixel is not consumed.
REQ-032 Pixels SHALL NOT be dropped or duplicated across image boundaries; the first pixel after DONE is index 0 of the next image.

Reset
REQ-033 Asynchronous assertion of rst_ni=0 SHALL immediately force:
- state=LOAD, all counters 0, s_ready=0, m_ena=m_wea=0, m_addra=0, m_dina=0, busy=0, done=0, win_cnt=0.
REQ-034 s_ready SHALL rise in the first clock after rst_ni deasserts.
REQ-035 Pixel buffer contents need not be reset.
REQ-036 Reset mid-image (load or issue) SHALL abandon the image; the next accepted pixel is raster index 0.

Verification
REQ-037 Feed pixel value = (r*IMG_W+c) mod 256 -> first writes:
- CLR 32'h8 at addr 16'h4000;
- COL0 dina 32'h001E0F00 at addr 16'h1000;
- COL1 32'h001F1001; COL2 32'h00201102;
- then TRIG 32'h1.
REQ-038 Full default image -> exactly 182 TRIG writes and 14 CLR writes; done pulses 1176 cycles after the first CLR cycle; win_cnt=182 when done is high.
REQ-039 Check every write is followed by m_ena=0; TRIG-to-next-write spacing is exactly WAIT_CYC+1 cycles; repeat with WAIT_CYC=5.
REQ-040 s_valid toggled randomly during load, and held high during issue -> only 240 pixels consumed per image; second image output is correct.
REQ-041 rst_ni pulsed low mid-row 5, between clock edges -> outputs 0 before the next edge; a fresh image produces the REQ-037 sequence.
REQ-042 Last window: COL at c=14 for wr=13 carries pix[13..15][14] = 32'h00EFE0D1, followed by TRIG, WAIT, then done.
